// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants, FSM encoding and register-use helpers for the
// decode-stage hazard controller and its load-use detector.
package hazard_ctrl_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;

  localparam logic [OPC_W-1:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPCODE_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Register-read usage by opcode; shared with the forwarding unit.
  function automatic logic uses_rs1(input logic [OPC_W-1:0] opcode);
    return !((opcode == OPCODE_LUI) || (opcode == OPCODE_AUIPC) ||
             (opcode == OPCODE_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
    return (opcode == OPCODE_OP) || (opcode == OPCODE_STORE) ||
           (opcode == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detect between the IF/ID instruction and a
// load sitting in EX. Takes only the instruction fields it actually decodes.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             id_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = uses_rs1(opcode_i) && (rs1_i == ex_rd_i);
  assign rs2_hit = uses_rs2(opcode_i) && (rs2_i == ex_rd_i);

  // x0 never carries a real dependency.
  assign load_use_o = id_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                      (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline controller: owns the IF/ID register, stalls on
// load-use, flushes on EX redirects, halts on ECALL/EBREAK until resume.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned       CNT_W    = 16,
  parameter logic [INST_W-1:0] NOP_INST = hazard_ctrl_pkg::NOP_INST
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_valid_i,
  input  logic [INST_W-1:0] if_inst_i,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic              ex_redirect_i,
  input  logic              resume_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic              id_valid_o,
  output logic              pc_write_o,
  output logic              id_ex_bubble_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_e            state_q;
  state_e            state_d;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   pc_q;
  logic              valid_q;
  logic              halted_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              load_use;
  logic              sys_halt;
  logic              ifid_load;
  logic              ifid_flush;
  logic              stall_inc;
  logic              flush_inc;

  hazard_ctrl_load_use_detect u_load_use_detect (
    .opcode_i      (inst_q[6:0]),
    .rs1_i         (inst_q[19:15]),
    .rs2_i         (inst_q[24:20]),
    .id_valid_i    (valid_q),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .load_use_o    (load_use)
  );

  // ECALL and EBREAK share opcode SYSTEM with funct3 zero.
  assign sys_halt = valid_q && (inst_q[6:0] == OPCODE_SYSTEM) &&
                    (inst_q[14:12] == F3_W'(0));

  // Next-state and per-cycle pipeline control.
  always_comb begin
    state_d        = state_q;
    pc_write_o     = 1'b1;
    id_ex_bubble_o = 1'b0;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (rst_i) begin
      id_ex_bubble_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_redirect_i) begin
            id_ex_bubble_o = 1'b1;
            ifid_flush     = 1'b1;
            flush_inc      = 1'b1;
          end else if (sys_halt) begin
            pc_write_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
            state_d        = ST_HALT;
          end else if (load_use) begin
            pc_write_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_inc      = 1'b1;
          end else begin
            ifid_load = 1'b1;
          end
        end
        ST_HALT: begin
          pc_write_o     = 1'b0;
          id_ex_bubble_o = 1'b1;
          if (resume_i) begin
            pc_write_o = 1'b1;
            ifid_load  = 1'b1;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, IF/ID register and saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      inst_q      <= NOP_INST;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
      if (ifid_flush) begin
        inst_q  <= NOP_INST;
        pc_q    <= '0;
        valid_q <= 1'b0;
      end else if (ifid_load) begin
        inst_q  <= if_valid_i ? if_inst_i : NOP_INST;
        pc_q    <= if_pc_i;
        valid_q <= if_valid_i;
      end
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign id_inst_o   = inst_q;
  assign id_pc_o     = pc_q;
  assign id_valid_o  = valid_q;
  assign halted_o    = halted_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, all
// compared against a behavioural decode-stage model.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD_HAZ = 32'h0012_8333;  // add x6,x5,x1
  localparam logic [31:0] ECALL   = 32'h0000_0073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      if_pc;
  logic             mem_read;
  logic [4:0]       ex_rd;
  logic             redirect;
  logic             resume;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic             id_valid;
  logic             pc_write;
  logic             bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .NOP_INST(NOP)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .if_valid_i     (if_valid),
    .if_inst_i      (if_inst),
    .if_pc_i        (if_pc),
    .ex_mem_read_i  (mem_read),
    .ex_rd_i        (ex_rd),
    .ex_redirect_i  (redirect),
    .resume_i       (resume),
    .id_inst_o      (id_inst),
    .id_pc_o        (id_pc),
    .id_valid_o     (id_valid),
    .pc_write_o     (pc_write),
    .id_ex_bubble_o (bubble),
    .halted_o       (halted),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // Reference model: what the decode stage should hold after each edge.
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_halted;
  int          m_stall;
  int          m_flush;
  bit          m_known;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] op;
    bit         r1;
    bit         r2;
    op = inst[6:0];
    r1 = !(op inside {7'h37, 7'h17, 7'h6f});
    r2 = op inside {7'h33, 7'h23, 7'h63};
    return (r1 && inst[19:15] == r) || (r2 && inst[24:20] == r);
  endfunction

  function automatic bit m_load_use();
    return m_valid && mem_read && (ex_rd != 5'd0) && reads_reg(m_inst, ex_rd);
  endfunction

  function automatic bit m_sys();
    return m_valid && (m_inst[6:0] == 7'h73) && (m_inst[14:12] == 3'd0);
  endfunction

  task automatic check_regs();
    if (m_known) begin
      check("id_inst", id_inst, m_inst);
      check("id_pc", id_pc, m_pc);
      check("id_valid", 32'(id_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  endtask

  task automatic model_fetch();
    m_inst  = if_valid ? if_inst : NOP;
    m_pc    = if_pc;
    m_valid = if_valid;
  endtask

  // One cycle: check registered state, drive, check same-cycle control, clock the model.
  task automatic cyc(input bit r, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                     input bit mr, input logic [4:0] rd, input bit re, input bit rs);
    bit exp_pw;
    bit exp_bb;
    @(negedge clk);
    check_regs();
    rst = r; if_valid = v; if_inst = inst; if_pc = pc;
    mem_read = mr; ex_rd = rd; redirect = re; resume = rs;
    #1;
    if (rst)                 begin exp_pw = 1'b1; exp_bb = 1'b1; end
    else if (!m_known)       begin exp_pw = pc_write; exp_bb = bubble; end
    else if (m_halted)       begin exp_pw = resume;   exp_bb = 1'b1; end
    else if (redirect)       begin exp_pw = 1'b1;     exp_bb = 1'b1; end
    else if (m_sys())        begin exp_pw = 1'b0;     exp_bb = 1'b1; end
    else if (m_load_use())   begin exp_pw = 1'b0;     exp_bb = 1'b1; end
    else                     begin exp_pw = 1'b1;     exp_bb = 1'b0; end
    if (rst || m_known) begin
      check("pc_write", 32'(pc_write), 32'(exp_pw));
      check("bubble", 32'(bubble), 32'(exp_bb));
    end
    @(posedge clk);
    if (rst) begin
      m_inst = NOP; m_pc = '0; m_valid = 0; m_halted = 0;
      m_stall = 0; m_flush = 0; m_known = 1;
    end else if (m_known) begin
      if (m_halted) begin
        if (resume) begin m_halted = 0; model_fetch(); end
      end else if (redirect) begin
        m_inst = NOP; m_pc = '0; m_valid = 0;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (m_sys()) begin
        m_halted = 1;
      end else if (m_load_use()) begin
        if (m_stall < CNT_MAX) m_stall++;
      end else begin
        model_fetch();
      end
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17, 7'h73};
    op = ops[$urandom_range(0, 9)];
    f3 = (op == 7'h73) ? 3'($urandom_range(0, 1)) : 3'($urandom);
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
            5'($urandom_range(0, 3)), op};
  endfunction

  initial begin
    m_known = 0;
    m_inst = NOP; m_pc = '0; m_valid = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    rst = 1; if_valid = 0; if_inst = '0; if_pc = '0;
    mem_read = 0; ex_rd = '0; redirect = 0; resume = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 32'h100, 0, 0, 0, 0);
    cyc(0, 1, ADD_HAZ, 32'h104, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 32'h108, 1, 5'd5, 0, 0);   // load-use stall
    cyc(0, 1, 32'h0050_0293, 32'h108, 0, 0, 0, 0);      // stall clears, advance
    cyc(0, 1, ADD_HAZ, 32'h10c, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_52b7, 32'h110, 1, 5'd0, 0, 0);   // x0 target, no stall
    cyc(0, 1, NOP, 32'h114, 1, 5'd5, 0, 0);             // lui ignores rs1
    cyc(0, 1, ADD_HAZ, 32'h118, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 32'h11c, 1, 5'd5, 1, 0);   // redirect beats load-use
    cyc(0, 1, ECALL, 32'h200, 0, 0, 0, 0);
    cyc(0, 1, 32'h0050_0293, 32'h204, 0, 0, 0, 0);      // halt detected
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h0050_0293, 32'h204, i[0], 5'd1, ~i[0], 0);
    cyc(0, 1, 32'h00a0_0313, 32'h204, 0, 0, 0, 1);      // resume
    cyc(0, 0, 32'hdead_beef, 32'h208, 0, 0, 0, 0);      // invalid fetch loads NOP

    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, ADD_HAZ, 32'h300, 0, 0, 0, 0);
      cyc(0, 1, NOP, 32'h304, 1, 5'd1, 0, 0);
    end
    @(negedge clk);
    check("stall_sat", 32'(stall_cnt), 32'(CNT_MAX));

    cyc(0, 1, ECALL, 32'h400, 0, 0, 0, 0);
    cyc(0, 1, NOP, 32'h404, 0, 0, 0, 0);
    cyc(0, 1, NOP, 32'h404, 0, 0, 0, 0);
    cyc(1, 1, NOP, 32'h404, 0, 0, 0, 0);                // reset while halted
    cyc(0, 1, NOP, 32'h408, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), rand_inst(),
          $urandom & 32'hffff_fffc, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 25));
    end
    @(negedge clk);
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
